pong_bar_scheduler: RTL and testbench

Arbitrates paddle-move requests from two requesters (left and right player) and sequences the position updates of both Pong bars. Each move is clamped to the playfield and rate-limited by a hold delay. A move is committed only when the bar drawer is not emitting a bar pixel. The block sits between the custom-instruction and input decoders on one side and the two bar drawers on the other, and it is the single owner of both bar y-positions.

---
 rtl/pong_bar_scheduler.sv | 130 +++++++++++++
 tb/tb_pong_bar_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pong_bar_scheduler.sv
// Round-robin scheduler for the two Pong bar positions: grants one move request,
// clamps it to the playfield, waits out a hold delay, then commits it while no bar pixel is being drawn.
module pong_bar_scheduler #(
  parameter int Y_INIT = 195,
  parameter int Y_MIN  = 6,
  parameter int Y_MAX  = 383,
  parameter int HOLD   = 1048575
) (
  input  logic       clk_in,
  input  logic       i_rst,
  input  logic       enablePong,
  input  logic       req0,
  input  logic       req1,
  input  logic       incDec0,
  input  logic       incDec1,
  input  logic [8:0] step0,
  input  logic [8:0] step1,
  input  logic       draw_busy,
  output logic       ack0,
  output logic       ack1,
  output logic [8:0] y_bar0,
  output logic [8:0] y_bar1,
  output logic       busy,
  output logic       grant_id
);

  localparam int               CNT_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
  localparam logic [9:0]       YMIN_W   = 10'(Y_MIN);
  localparam logic [9:0]       YMAX_W   = 10'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD, S_WAIT} state_t;

  state_t           state, state_nx;
  logic             ptr, ptr_nx;
  logic             gid, gid_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             grant, commit;
  logic             dir_l;
  logic [8:0]       step_l;
  logic [8:0]       target;

  // Saturate a move to [Y_MIN, Y_MAX] using 10-bit headroom so the sum cannot wrap.
  function automatic logic [8:0] clamp_move(input logic [8:0] y, input logic down,
                                            input logic [8:0] step);
    logic [9:0] sum;
    logic [9:0] room;
    sum  = {1'b0, y} + {1'b0, step};
    room = {1'b0, y} - YMIN_W;
    if (down)
      clamp_move = (sum > YMAX_W) ? YMAX_W[8:0] : sum[8:0];
    else
      clamp_move = ({1'b0, step} > room) ? YMIN_W[8:0] : (y - step);
  endfunction

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gid_nx   = gid;
    cnt_nx   = cnt;
    grant    = 1'b0;
    commit   = 1'b0;
    if (!enablePong) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            grant    = 1'b1;
            // On a tie the requester not served last wins.
            gid_nx   = (req0 && req1) ? ~ptr : req1;
            ptr_nx   = gid_nx;
            state_nx = S_CALC;
          end
        end
        S_CALC: begin
          cnt_nx   = '0;
          state_nx = S_HOLD;
        end
        S_HOLD: begin
          if (cnt == CNT_LAST) state_nx = S_WAIT;
          else                 cnt_nx   = cnt + 1'b1;
        end
        S_WAIT: begin
          if (!draw_busy) begin
            commit   = 1'b1;
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      ptr    <= 1'b1;
      gid    <= 1'b0;
      cnt    <= '0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      y_bar0 <= 9'(Y_INIT);
      y_bar1 <= 9'(Y_INIT);
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      gid   <= gid_nx;
      cnt   <= cnt_nx;
      ack0  <= commit & ~gid;
      ack1  <= commit & gid;
      if (commit && !gid) y_bar0 <= target;
      if (commit &&  gid) y_bar1 <= target;
    end
  end

  // Transaction operands are captured at grant and never re-sampled.
  always_ff @(posedge clk_in) begin
    if (grant) begin
      dir_l  <= gid_nx ? incDec1 : incDec0;
      step_l <= gid_nx ? step1 : step0;
    end
    if (state == S_CALC)
      target <= clamp_move(gid ? y_bar1 : y_bar0, dir_l, step_l);
  end

  assign busy     = (state != S_IDLE);
  assign grant_id = gid;

endmodule

// File: tb/tb_pong_bar_scheduler.sv
// Bench for pong_bar_scheduler: table of single moves plus hand-written
// reset, round-robin, draw-gating and abort sequences, checked through an expectation queue.
module tb_pong_bar_scheduler;

  logic       clk_in = 1'b0;
  logic       i_rst, enablePong, req0, req1, incDec0, incDec1, draw_busy;
  logic [8:0] step0, step1, y_bar0, y_bar1;
  logic       ack0, ack1, busy, grant_id;

  int checks   = 0;
  int failures = 0;

  typedef struct {logic pl; logic [8:0] y0; logic [8:0] y1;} exp_t;
  typedef struct {logic pl; logic dir; logic [8:0] step; logic [8:0] exp_y;} vec_t;

  exp_t       exp_q[$];
  vec_t       vecs[11];
  logic [8:0] m_y0, m_y1;

  always #5 clk_in = ~clk_in;

  pong_bar_scheduler #(.Y_INIT(195), .Y_MIN(6), .Y_MAX(383), .HOLD(4)) dut (
    .clk_in(clk_in), .i_rst(i_rst), .enablePong(enablePong),
    .req0(req0), .req1(req1), .incDec0(incDec0), .incDec1(incDec1),
    .step0(step0), .step1(step1), .draw_busy(draw_busy),
    .ack0(ack0), .ack1(ack1), .y_bar0(y_bar0), .y_bar1(y_bar1),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input logic pl);
    exp_t e;
    e.pl = pl; e.y0 = m_y0; e.y1 = m_y1;
    exp_q.push_back(e);
  endtask

  // Counts edges from the call until an ack appears, then checks against the queue head.
  task automatic await_commit(input string name, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(posedge clk_in); #1;
      lat++;
    end while (!(ack0 || ack1) && lat < 60);
    check({name, "_latency"}, lat, exp_lat);
    if (exp_q.size() == 0) begin
      check({name, "_queue_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_ack0"}, ack0, !e.pl);
      check({name, "_ack1"}, ack1, e.pl);
      check({name, "_y0"}, y_bar0, e.y0);
      check({name, "_y1"}, y_bar1, e.y1);
    end
  endtask

  task automatic run_move(input string name, input logic pl, input logic dir,
                          input logic [8:0] step, input logic [8:0] exp_y);
    @(negedge clk_in);
    if (pl) begin req1 = 1'b1; incDec1 = dir; step1 = step; m_y1 = exp_y; end
    else    begin req0 = 1'b1; incDec0 = dir; step0 = step; m_y0 = exp_y; end
    push_exp(pl);
    @(posedge clk_in); #1;
    check({name, "_busy"}, busy, 1);
    check({name, "_grant_id"}, grant_id, pl);
    await_commit(name, 6);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk_in); #1;
    check({name, "_ack_drop"}, {ack0, ack1}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable, seen_ack, idle_ok;
    vecs[0]  = '{1'b0, 1'b1, 9'd20,  9'd215};
    vecs[1]  = '{1'b1, 1'b1, 9'd300, 9'd383};
    vecs[2]  = '{1'b1, 1'b0, 9'd500, 9'd6};
    vecs[3]  = '{1'b1, 1'b0, 9'd0,   9'd6};
    vecs[4]  = '{1'b1, 1'b0, 9'd1,   9'd6};
    vecs[5]  = '{1'b0, 1'b0, 9'd15,  9'd200};
    vecs[6]  = '{1'b1, 1'b1, 9'd377, 9'd383};
    vecs[7]  = '{1'b1, 1'b1, 9'd1,   9'd383};
    vecs[8]  = '{1'b0, 1'b0, 9'd194, 9'd6};
    vecs[9]  = '{1'b0, 1'b1, 9'd511, 9'd383};
    vecs[10] = '{1'b0, 1'b0, 9'd378, 9'd6};

    i_rst = 1'b1; enablePong = 1'b1; req0 = 1'b0; req1 = 1'b0;
    incDec0 = 1'b0; incDec1 = 1'b0; step0 = '0; step1 = '0; draw_busy = 1'b0;
    m_y0 = 9'd195; m_y1 = 9'd195;
    #12;
    check("rst_y0", y_bar0, 195);
    check("rst_y1", y_bar1, 195);
    check("rst_busy", busy, 0);
    check("rst_acks", {ack0, ack1}, 0);
    check("rst_grant_id", grant_id, 0);
    @(negedge clk_in); i_rst = 1'b0;

    for (int i = 0; i < 11; i++)
      run_move($sformatf("vec%0d", i), vecs[i].pl, vecs[i].dir, vecs[i].step, vecs[i].exp_y);

    // Asynchronous reset in the middle of the hold delay.
    @(negedge clk_in); req1 = 1'b1; incDec1 = 1'b1; step1 = 9'd50;
    @(posedge clk_in); #1;
    check("midrst_grant_id", grant_id, 1);
    repeat (3) @(posedge clk_in);
    #1 check("midrst_busy_before", busy, 1);
    @(negedge clk_in); i_rst = 1'b1; req1 = 1'b0;
    #1;
    check("midrst_y0", y_bar0, 195);
    check("midrst_y1", y_bar1, 195);
    check("midrst_busy", busy, 0);
    check("midrst_acks", {ack0, ack1}, 0);
    check("midrst_grant_id", grant_id, 0);

    // Both requests held from reset release: alternate 0,1,0,1 every 7 cycles.
    m_y0 = 9'd195; m_y1 = 9'd195;
    req0 = 1'b1; req1 = 1'b1; incDec0 = 1'b1; incDec1 = 1'b1; step0 = 9'd1; step1 = 9'd2;
    m_y0 = 9'd196; push_exp(1'b0);
    m_y1 = 9'd197; push_exp(1'b1);
    m_y0 = 9'd197; push_exp(1'b0);
    m_y1 = 9'd199; push_exp(1'b1);
    @(negedge clk_in); i_rst = 1'b0;
    for (int i = 0; i < 4; i++) await_commit($sformatf("rr%0d", i), 7);
    req0 = 1'b0; req1 = 1'b0;

    // Drawer busy across the end of the hold delay.
    @(negedge clk_in); req0 = 1'b1; incDec0 = 1'b1; step0 = 9'd10; m_y0 = 9'd207;
    push_exp(1'b0);
    @(posedge clk_in); #1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in); draw_busy = 1'b1;
    stable = 1'b1; seen_ack = 1'b0;
    repeat (10) begin
      @(posedge clk_in); #1;
      if (y_bar0 !== 9'd197) stable = 1'b0;
      if (ack0 || ack1) seen_ack = 1'b1;
    end
    check("gate_y_stable", stable, 1);
    check("gate_no_early_ack", seen_ack, 0);
    @(negedge clk_in); draw_busy = 1'b0;
    await_commit("gate", 1);
    req0 = 1'b0;

    // Abort during the hold delay, then re-grant once enabled again.
    @(negedge clk_in); req1 = 1'b1; incDec1 = 1'b1; step1 = 9'd5;
    @(posedge clk_in); #1;
    check("abort_busy", busy, 1);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in); enablePong = 1'b0;
    @(posedge clk_in); #1;
    check("abort_idle", busy, 0);
    check("abort_no_ack", {ack0, ack1}, 0);
    check("abort_y1", y_bar1, 199);
    check("abort_y0", y_bar0, 207);
    idle_ok = 1'b1;
    repeat (3) begin
      @(posedge clk_in); #1;
      if (busy || ack0 || ack1) idle_ok = 1'b0;
    end
    check("disabled_no_grant", idle_ok, 1);
    @(negedge clk_in); enablePong = 1'b1; m_y1 = 9'd204;
    push_exp(1'b1);
    await_commit("regrant", 7);
    req1 = 1'b0;
    @(posedge clk_in); #1;
    check("regrant_ack_drop", {ack0, ack1}, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
